// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types and constants
package cpu_pkg;
    localparam int INSTR_W = 32;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous {pc, instruction} FIFO with push/pop/flush and occupancy flags
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == FULL_C);
    assign count_o = count;
    assign rdata_o = mem[rd_ptr];

    // a push into a full FIFO is accepted when the head leaves on the same edge
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wr_ptr] <= wdata_i;
    end
endmodule

// File: rtl/ifetch_prefetch_queue.sv
// rtl/ifetch_prefetch_queue.sv - run-ahead instruction fetch with redirect flush and prefetch FIFO
// IFETCH_BYPASS_EN: forwards an ack straight to the outputs when the FIFO is empty
module ifetch_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               imem_req_o,
    output logic [31:0]        imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    output logic [INSTR_W-1:0] inst_o,
    output logic [31:0]        pc_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    fetch_state_t state, state_next;
    logic [31:0]  fetch_pc, fetch_pc_next, drop_pc, drop_pc_next, target;
    logic         push, pop, bypass, fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW:0]  count_next;
    logic [63:0]  fifo_rdata;

    assign target = redirect_pc_i & ~32'h3;
    assign push   = (state == REQ) && imem_ack_i && !redirect_i;

`ifdef IFETCH_BYPASS_EN
    assign bypass = push && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign inst_valid_o = !fifo_empty || bypass;
    assign pop          = inst_valid_o && inst_ready_i;
    // a bypassed word taken this cycle never touches storage
    assign fifo_wr      = push && !(bypass && inst_ready_i);
    assign fifo_rd      = pop && !bypass;
    assign count_next   = {1'b0, fifo_count} + (CW+1)'(fifo_wr) - (CW+1)'(fifo_rd);

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_wr),
        .pop_i   (fifo_rd),
        .flush_i (redirect_i),
        .wdata_i ({fetch_pc, imem_data_i}),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            drop_pc  <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            drop_pc  <= drop_pc_next;
        end
    end

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        drop_pc_next  = drop_pc;
        case (state)
            IDLE: begin
                if (redirect_i) begin
                    fetch_pc_next = target;
                    state_next    = REQ;
                end else if (!fifo_full || fifo_rd) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    fetch_pc_next = target;
                    // an unanswered request must still be retired before the target is issued
                    if (!imem_ack_i) begin
                        drop_pc_next = fetch_pc;
                        state_next   = DROP;
                    end
                end else if (imem_ack_i) begin
                    fetch_pc_next = fetch_pc + PC_INC;
                    state_next    = (count_next < DEPTH_C) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (redirect_i) fetch_pc_next = target;
                if (imem_ack_i) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = '0;
        case (state)
            REQ: begin
                imem_req_o  = 1'b1;
                imem_addr_o = fetch_pc;
            end
            DROP: begin
                imem_req_o  = 1'b1;
                imem_addr_o = drop_pc;
            end
            default: ;
        endcase
    end

    always_comb begin
        inst_o = '0;
        pc_o   = '0;
        if (bypass) begin
            inst_o = imem_data_i;
            pc_o   = fetch_pc;
        end else if (!fifo_empty) begin
            pc_o   = fifo_rdata[63:32];
            inst_o = fifo_rdata[31:0];
        end
    end
endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// tb/tb_ifetch_prefetch_queue.sv - randomized fetch-queue bench against a program-order stream model
module tb_ifetch_prefetch_queue;
`ifdef IFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o, imem_ack_i = 1'b0;
    logic [31:0] imem_addr_o, imem_data_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        inst_valid_o, inst_ready_i = 1'b0;
    logic [31:0] inst_o, pc_o;

    always #5 clk = ~clk;

    ifetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .pc_o(pc_o)
    );

    int vectors = 0, miscompares = 0;
    int wcnt, cur_lat, fixed_lat = 0, pushes, pops, chk_done;
    bit rand_lat = 0;
    logic [31:0] exp_pc, last_tgt, prev_addr, next_addr, first_pc, obs_pc;
    logic prev_req, prev_ack, dropping, chk_next, have_first, obs_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic do_reset();
        rst_i = 1'b1; imem_ack_i = 1'b0; redirect_i = 1'b0; inst_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        exp_pc = 32'h0; last_tgt = 32'h0; wcnt = 0; cur_lat = fixed_lat;
        prev_req = 0; prev_ack = 0; dropping = 0; chk_next = 0;
        pushes = 0; pops = 0; chk_done = 0; have_first = 0;
    endtask

    // one clock: memory model answers, inputs applied, outputs scored against program order
    task automatic cycle(input bit rdy, input bit redir, input logic [31:0] tgt);
        logic req_now, ack_now, was_drop;
        logic [31:0] addr_now;
        req_now = imem_req_o; addr_now = imem_addr_o;
        if (prev_req && !prev_ack) begin
            vectors++;
            if (req_now !== 1'b1 || addr_now !== prev_addr) begin
                $display("FAIL hold: req=%b addr=%h, required req=1 addr=%h", req_now, addr_now, prev_addr);
                miscompares++;
            end
        end
        if (chk_next) begin
            vectors++; chk_done++;
            if (req_now !== 1'b1 || addr_now !== next_addr) begin
                $display("FAIL next_addr: req=%b addr=%h, required req=1 addr=%h", req_now, addr_now, next_addr);
                miscompares++;
            end
            chk_next = 0;
        end
        ack_now = 1'b0;
        if (req_now) begin
            if (wcnt >= cur_lat) begin
                ack_now = 1'b1; wcnt = 0;
                cur_lat = rand_lat ? int'($urandom_range(0, 2)) : fixed_lat;
            end else wcnt++;
        end
        imem_ack_i = ack_now;
        imem_data_i = ack_now ? mem_word(addr_now) : $urandom();
        inst_ready_i = rdy; redirect_i = redir; redirect_pc_i = tgt;
        #1;
        obs_valid = inst_valid_o; obs_pc = pc_o;
        if (inst_valid_o && rdy && !redir) begin
            vectors++;
            if (pc_o !== exp_pc || inst_o !== mem_word(exp_pc)) begin
                $display("FAIL stream: pc=%h inst=%h, required pc=%h inst=%h", pc_o, inst_o, exp_pc, mem_word(exp_pc));
                miscompares++;
            end
            if (!have_first) begin have_first = 1; first_pc = pc_o; end
            exp_pc += 32'd4; pops++;
        end
        was_drop = dropping;
        if (req_now && ack_now && !redir && !was_drop) pushes++;
        if (redir) begin
            exp_pc = {tgt[31:2], 2'b00}; last_tgt = exp_pc; have_first = 0;
            if (!req_now || ack_now) begin chk_next = 1; next_addr = last_tgt; dropping = 0; end
            else dropping = 1;
        end else if (was_drop && ack_now) begin
            chk_next = 1; next_addr = last_tgt; dropping = 0;
        end
        prev_req = req_now; prev_ack = ack_now; prev_addr = addr_now;
        @(posedge clk); #1;
        imem_ack_i = 1'b0; redirect_i = 1'b0;
    endtask

    task automatic wait_addr8(output bit found);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (imem_req_o && imem_addr_o == 32'h8 && wcnt == 0) found = 1;
            else cycle(1, 0, 0);
        end
        vectors++;
        if (!found) begin
            $display("FAIL wait_addr8: request at 0x8 not seen within 60 cycles, required seen");
            miscompares++;
        end
    endtask

    task automatic test_reset();
        fixed_lat = 0; rand_lat = 0;
        rst_i = 1'b1; #1;
        vectors++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0 || inst_valid_o !== 1'b0 || inst_o !== 32'h0 || pc_o !== 32'h0) begin
            $display("FAIL reset_state: req=%b addr=%h valid=%b inst=%h pc=%h, required all zero",
                     imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o);
            miscompares++;
        end
    endtask

    task automatic test_latency();
        fixed_lat = 0; rand_lat = 0; do_reset();
        cycle(0, 0, 0);
        vectors++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            $display("FAIL first_req: req=%b addr=%h, required req=1 addr=00000000", imem_req_o, imem_addr_o);
            miscompares++;
        end
        cycle(0, 0, 0);
        vectors++;
        if (obs_valid !== BYP) begin
            $display("FAIL ack_cycle_valid: valid=%b, required %b", obs_valid, BYP);
            miscompares++;
        end
        cycle(0, 0, 0);
        vectors++;
        if (obs_valid !== 1'b1 || obs_pc !== 32'h0) begin
            $display("FAIL ack_plus1_valid: valid=%b pc=%h, required valid=1 pc=00000000", obs_valid, obs_pc);
            miscompares++;
        end
    endtask

    task automatic test_stream();
        fixed_lat = 0; rand_lat = 0; do_reset();
        repeat (20) cycle(1, 0, 0);
        vectors++;
        if (pops != (BYP ? 19 : 18)) begin
            $display("FAIL throughput: pops=%0d, required %0d", pops, BYP ? 19 : 18);
            miscompares++;
        end
    endtask

    task automatic test_stall();
        fixed_lat = 0; rand_lat = 0; do_reset();
        repeat (10) cycle(0, 0, 0);
        vectors++;
        if (pushes != DEPTH || imem_req_o !== 1'b0 || inst_valid_o !== 1'b1 || pc_o !== 32'h0) begin
            $display("FAIL stall_full: pushes=%0d req=%b valid=%b pc=%h, required pushes=%0d req=0 valid=1 pc=0",
                     pushes, imem_req_o, inst_valid_o, pc_o, DEPTH);
            miscompares++;
        end
        repeat (20) cycle(1, 0, 0);
        vectors++;
        if (pops < 15) begin
            $display("FAIL stall_release: pops=%0d, required >= 15", pops);
            miscompares++;
        end
    endtask

    task automatic test_redirect_pending();
        bit found;
        fixed_lat = 3; rand_lat = 0; do_reset();
        wait_addr8(found);
        if (found) begin
            cycle(1, 1, 32'h100);
            repeat (20) cycle(1, 0, 0);
            vectors++;
            if (!have_first || first_pc !== 32'h100 || chk_done < 1) begin
                $display("FAIL redirect_pending: have=%b first_pc=%h addr_checks=%0d, required first_pc=00000100", have_first, first_pc, chk_done);
                miscompares++;
            end
        end
    endtask

    task automatic test_redirect_ack_pop();
        fixed_lat = 0; rand_lat = 0; do_reset();
        repeat (4) cycle(0, 0, 0);
        cycle(1, 1, 32'h40);
        vectors++;
        if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
            $display("FAIL redirect_ack_pop: valid=%b req=%b addr=%h, required valid=0 req=1 addr=00000040",
                     inst_valid_o, imem_req_o, imem_addr_o);
            miscompares++;
        end
        repeat (10) cycle(1, 0, 0);
        vectors++;
        if (!have_first || first_pc !== 32'h40) begin
            $display("FAIL redirect_first: have=%b first_pc=%h, required 00000040", have_first, first_pc);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        bit found;
        fixed_lat = 3; rand_lat = 0; do_reset();
        wait_addr8(found);
        if (found) begin
            cycle(1, 1, 32'h200);
            cycle(1, 1, 32'h300);
            repeat (20) cycle(1, 0, 0);
            vectors++;
            if (!have_first || first_pc !== 32'h300 || chk_done < 1) begin
                $display("FAIL back_to_back: have=%b first_pc=%h addr_checks=%0d, required first_pc=00000300", have_first, first_pc, chk_done);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid();
        fixed_lat = 3; rand_lat = 0; do_reset();
        repeat (3) cycle(1, 0, 0);
        rst_i = 1'b1; imem_ack_i = 1'b1; imem_data_i = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0 || inst_valid_o !== 1'b0 || inst_o !== 32'h0 || pc_o !== 32'h0) begin
            $display("FAIL reset_mid: req=%b addr=%h valid=%b inst=%h pc=%h, required all zero",
                     imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o);
            miscompares++;
        end
        repeat (2) @(posedge clk);
        do_reset();
        imem_ack_i = 1'b1; imem_data_i = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (inst_valid_o !== 1'b0) begin
            $display("FAIL stray_ack: valid=%b, required 0", inst_valid_o);
            miscompares++;
        end
        @(posedge clk); #1; imem_ack_i = 1'b0;
        vectors++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            $display("FAIL restart_pc: req=%b addr=%h, required req=1 addr=00000000", imem_req_o, imem_addr_o);
            miscompares++;
        end
        repeat (15) cycle(1, 0, 0);
        vectors++;
        if (!have_first || first_pc !== 32'h0) begin
            $display("FAIL restart_first: have=%b first_pc=%h, required 00000000", have_first, first_pc);
            miscompares++;
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        bit rdy, redir;
        fixed_lat = 1; rand_lat = 1; do_reset();
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            t = $urandom() & 32'h0000_03FF;
            redir = ($urandom_range(0, 19) == 0) && !(i > 150 && i < 175);
            if (i == 150) begin redir = 1; t = 32'hFFFF_FFF6; end
            cycle(rdy, redir, t);
        end
        vectors++;
        if (pops < 40) begin
            $display("FAIL random_progress: pops=%0d, required >= 40", pops);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stream();
        test_stall();
        test_redirect_pending();
        test_redirect_ack_pop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
